// File: rtl/ex_stage_muldiv.sv
// rtl/ex_stage_muldiv.sv - EX stage: single-cycle ALU with destination select plus
// an iterative 32-step MULT/MULTU/DIV/DIVU unit that owns HI/LO and stalls the front end.
module ex_stage_muldiv #(
  parameter int W     = 32,
  parameter int CNT_W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         valid_in,
  input  logic [3:0]   ex_ctrl,
  input  logic [31:0]  instruction,
  input  logic [W-1:0] reg1,
  input  logic [W-1:0] reg2,
  input  logic [W-1:0] sign_extend,
  input  logic [4:0]   rt,
  input  logic [4:0]   rd,
  output logic [W-1:0] alu_result,
  output logic         zero,
  output logic [4:0]   dest_reg,
  output logic         stall,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);

  localparam logic [5:0] F_SLL   = 6'h00;
  localparam logic [5:0] F_SRL   = 6'h02;
  localparam logic [5:0] F_SRA   = 6'h03;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_SUBU  = 6'h23;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_XOR   = 6'h26;
  localparam logic [5:0] F_NOR   = 6'h27;
  localparam logic [5:0] F_SLT   = 6'h2A;
  localparam logic [5:0] F_SLTU  = 6'h2B;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(W - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  logic [1:0]   alu_op;
  logic [5:0]   funct;
  logic [4:0]   shamt;
  logic [W-1:0] op_b;
  logic [W-1:0] sum_ab;
  logic [W-1:0] diff_ab;
  logic         lt_signed;
  logic         lt_unsigned;
  logic         unused_bits;

  assign alu_op      = ex_ctrl[2:1];
  assign funct       = instruction[5:0];
  assign shamt       = instruction[10:6];
  assign unused_bits = ^instruction[31:11];
  assign op_b        = ex_ctrl[0] ? sign_extend : reg2;
  assign sum_ab      = reg1 + op_b;
  assign diff_ab     = reg1 - op_b;
  assign lt_signed   = $signed(reg1) < $signed(op_b);
  assign lt_unsigned = reg1 < op_b;
  assign dest_reg    = ex_ctrl[3] ? rd : rt;
  assign zero        = (alu_result == '0);

  always_comb begin
    alu_result = '0;
    case (alu_op)
      2'b00: alu_result = sum_ab;
      2'b01: alu_result = diff_ab;
      2'b11: alu_result = {{(W-1){1'b0}}, lt_signed};
      default: begin
        case (funct)
          F_ADD, F_ADDU: alu_result = sum_ab;
          F_SUB, F_SUBU: alu_result = diff_ab;
          F_AND:         alu_result = reg1 & op_b;
          F_OR:          alu_result = reg1 | op_b;
          F_XOR:         alu_result = reg1 ^ op_b;
          F_NOR:         alu_result = ~(reg1 | op_b);
          F_SLT:         alu_result = {{(W-1){1'b0}}, lt_signed};
          F_SLTU:        alu_result = {{(W-1){1'b0}}, lt_unsigned};
          F_SLL:         alu_result = reg2 << shamt;
          F_SRL:         alu_result = reg2 >> shamt;
          F_SRA:         alu_result = $signed(reg2) >>> shamt;
          F_MFHI:        alu_result = hi;
          F_MFLO:        alu_result = lo;
          default:       alu_result = '0;
        endcase
      end
    endcase
  end

  // funct bit 1 selects divide, bit 0 selects the unsigned flavour.
  logic is_md;
  logic md_div;
  logic md_signed;
  logic start;

  assign is_md     = (alu_op == 2'b10) &&
                     (funct == F_MULT || funct == F_MULTU || funct == F_DIV || funct == F_DIVU);
  assign md_div    = funct[1];
  assign md_signed = ~funct[0];

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [W-1:0]     acc_hi;
  logic [W-1:0]     acc_lo;
  logic [W-1:0]     opnd;
  logic             op_div;
  logic             neg_lo;
  logic             neg_hi;
  logic             div_zero;

  assign start = valid_in & is_md & (state == S_IDLE) & ~flush;
  assign stall = ~rst & ~flush & (start | state == S_MUL | state == S_DIV);

  logic [W-1:0] abs_a;
  logic [W-1:0] abs_b;

  assign abs_a = (md_signed && reg1[W-1]) ? -reg1 : reg1;
  assign abs_b = (md_signed && reg2[W-1]) ? -reg2 : reg2;

  // acc_hi:acc_lo is the product shifting right for MUL, and remainder:dividend
  // shifting left for DIV; opnd holds the multiplicand or divisor magnitude.
  logic [W:0]     mul_sum;
  logic [W:0]     div_shift;
  logic [W:0]     div_diff;
  logic           div_ge;
  logic [W-1:0]   step_hi;
  logic [W-1:0]   step_lo;

  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(W+1){1'b0}});
    div_shift = {acc_hi, acc_lo[W-1]};
    div_diff  = div_shift - {1'b0, opnd};
    div_ge    = (div_shift >= {1'b0, opnd});
    if (op_div) begin
      step_hi = div_ge ? div_diff[W-1:0] : div_shift[W-1:0];
      step_lo = {acc_lo[W-2:0], div_ge};
    end else begin
      step_hi = mul_sum[W:1];
      step_lo = {mul_sum[0], acc_lo[W-1:1]};
    end
  end

  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   quot_fix;
  logic [W-1:0]   rem_fix;

  assign prod_fix = neg_lo ? -{step_hi, step_lo} : {step_hi, step_lo};
  assign quot_fix = div_zero ? '1 : (neg_lo ? -step_lo : step_lo);
  assign rem_fix  = neg_hi ? -step_hi : step_hi;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      count    <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      opnd     <= '0;
      op_div   <= 1'b0;
      neg_lo   <= 1'b0;
      neg_hi   <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else if (flush) begin
      state <= S_IDLE;
      count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            acc_hi   <= '0;
            acc_lo   <= abs_a;
            opnd     <= abs_b;
            op_div   <= md_div;
            neg_lo   <= md_signed & (reg1[W-1] ^ reg2[W-1]);
            neg_hi   <= md_signed & reg1[W-1];
            div_zero <= md_div & (reg2 == '0);
            count    <= '0;
            state    <= md_div ? S_DIV : S_MUL;
          end
        end
        S_MUL, S_DIV: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          count  <= count + 1'b1;
          if (count == LAST_CNT) begin
            state <= S_DONE;
            if (op_div) begin
              hi <= rem_fix;
              lo <= quot_fix;
            end else begin
              hi <= prod_fix[2*W-1:W];
              lo <= prod_fix[W-1:0];
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_stage_muldiv.sv
// tb/tb_ex_stage_muldiv.sv - self-checking bench for ex_stage_muldiv
module tb_ex_stage_muldiv;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        valid_in;
  logic [3:0]  ex_ctrl;
  logic [31:0] instruction;
  logic [31:0] reg1;
  logic [31:0] reg2;
  logic [31:0] sign_extend;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [31:0] alu_result;
  logic        zero;
  logic [4:0]  dest_reg;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int applied = 0;
  int miscompares = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  ex_stage_muldiv #(.W(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .flush(flush), .valid_in(valid_in), .ex_ctrl(ex_ctrl),
    .instruction(instruction), .reg1(reg1), .reg2(reg2), .sign_extend(sign_extend),
    .rt(rt), .rd(rd), .alu_result(alu_result), .zero(zero), .dest_reg(dest_reg),
    .stall(stall), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk_instr(input logic [4:0] sh, input logic [5:0] f);
    return 32'hABC0_0000 | {21'd0, sh, f};
  endfunction

  function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] ins,
                                          input logic [31:0] a, input logic [31:0] r2,
                                          input logic [31:0] se, input logic [31:0] h,
                                          input logic [31:0] l);
    logic [31:0] b;
    logic [4:0]  sh;
    b  = c[0] ? se : r2;
    sh = ins[10:6];
    case (c[2:1])
      2'b00: return a + b;
      2'b01: return a - b;
      2'b11: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      default: begin
        case (ins[5:0])
          6'h20, 6'h21: return a + b;
          6'h22, 6'h23: return a - b;
          6'h24: return a & b;
          6'h25: return a | b;
          6'h26: return a ^ b;
          6'h27: return ~(a | b);
          6'h2A: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
          6'h2B: return (a < b) ? 32'd1 : 32'd0;
          6'h00: return r2 << sh;
          6'h02: return r2 >> sh;
          6'h03: return 32'(int'(r2) >>> sh);
          6'h10: return h;
          6'h12: return l;
          default: return 32'd0;
        endcase
      end
    endcase
  endfunction

  // Returns {hi, lo} from plain 64-bit arithmetic.
  function automatic logic [63:0] ref_md(input logic [5:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
    longint      sa;
    longint      sb;
    longint      q;
    longint      r;
    logic [63:0] ua;
    logic [63:0] ub;
    logic [63:0] p;
    sa = longint'(int'(a));
    sb = longint'(int'(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (f)
      6'h18: begin p = 64'(sa * sb); return p; end
      6'h19: begin p = ua * ub; return p; end
      6'h1A: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        p = ua / ub;
        ua = ua % ub;
        return {ua[31:0], p[31:0]};
      end
    endcase
  endfunction

  task automatic run_md(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] e;
    int n;
    e = ref_md(f, a, b);
    @(posedge clk); #1;
    valid_in = 1'b1; ex_ctrl = 4'b1100; instruction = mk_instr(5'd0, f);
    reg1 = a; reg2 = b; flush = 1'b0;
    @(negedge clk);
    check("md_alu_result", alu_result, 64'd0);
    n = 0;
    while (stall && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("md_stall_cycles", 64'(n), 64'd33);
    check("md_hi", hi, e[63:32]);
    check("md_lo", lo, e[31:0]);
    m_hi = e[63:32];
    m_lo = e[31:0];
    @(posedge clk); #1;
    instruction = mk_instr(5'd0, 6'h12);
    @(negedge clk);
    check("next_mflo", alu_result, e[31:0]);
    check("next_stall", stall, 64'd0);
    @(posedge clk); #1;
    instruction = mk_instr(5'd0, 6'h10);
    @(negedge clk);
    check("next_mfhi", alu_result, e[63:32]);
    @(posedge clk); #1;
    valid_in = 1'b0;
  endtask

  typedef struct {
    logic [3:0]  ctrl;
    logic [31:0] ins;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] se;
    logic [31:0] exp_res;
    logic        exp_zero;
    logic [4:0]  exp_dest;
  } alu_vec_t;

  typedef struct {
    logic [5:0]  f;
    logic [31:0] a;
    logic [31:0] b;
  } md_vec_t;

  alu_vec_t tbl[10];
  md_vec_t  mdt[6];
  logic [5:0] fpool[20];

  initial begin
    tbl[0] = '{4'b1100, mk_instr(5'd0, 6'h20), 32'd7, 32'd5, 32'd0, 32'd12, 1'b0, 5'd9};
    tbl[1] = '{4'b0010, mk_instr(5'd0, 6'h00), 32'h1234, 32'h1234, 32'd0, 32'd0, 1'b1, 5'd4};
    tbl[2] = '{4'b1100, mk_instr(5'd0, 6'h2A), 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd1, 1'b0, 5'd9};
    tbl[3] = '{4'b1100, mk_instr(5'd0, 6'h2B), 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 1'b1, 5'd9};
    tbl[4] = '{4'b1100, mk_instr(5'd4, 6'h03), 32'd0, 32'h8000_0000, 32'd0, 32'hF800_0000, 1'b0, 5'd9};
    tbl[5] = '{4'b0001, mk_instr(5'd0, 6'h00), 32'd100, 32'd0, 32'hFFFF_FFFC, 32'd96, 1'b0, 5'd4};
    tbl[6] = '{4'b0111, mk_instr(5'd0, 6'h00), 32'hFFFF_FFFB, 32'd0, 32'd3, 32'd1, 1'b0, 5'd4};
    tbl[7] = '{4'b1100, mk_instr(5'd0, 6'h27), 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b0, 5'd9};
    tbl[8] = '{4'b1100, mk_instr(5'd0, 6'h3F), 32'd3, 32'd4, 32'd0, 32'd0, 1'b1, 5'd9};
    tbl[9] = '{4'b1100, mk_instr(5'd31, 6'h02), 32'd0, 32'h8000_0000, 32'd0, 32'd1, 1'b0, 5'd9};

    mdt[0] = '{6'h18, 32'hFFFF_FFFD, 32'd7};
    mdt[1] = '{6'h1A, 32'd7, 32'hFFFF_FFFE};
    mdt[2] = '{6'h1B, 32'd5, 32'd0};
    mdt[3] = '{6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    mdt[4] = '{6'h1A, 32'h8000_0000, 32'hFFFF_FFFF};
    mdt[5] = '{6'h1A, 32'hFFFF_FFF9, 32'd2};

    fpool = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B,
              6'h00, 6'h02, 6'h03, 6'h10, 6'h12, 6'h3F, 6'h18, 6'h19, 6'h1A, 6'h1B};

    // Reset with a mult presented: stall must stay low, HI/LO cleared.
    rst = 1'b1; flush = 1'b0; valid_in = 1'b1; ex_ctrl = 4'b1100;
    instruction = mk_instr(5'd0, 6'h18); reg1 = 32'd3; reg2 = 32'd4;
    sign_extend = '0; rt = 5'd4; rd = 5'd9;
    repeat (2) @(negedge clk);
    check("reset_stall", stall, 64'd0);
    check("reset_hi", hi, 64'd0);
    check("reset_lo", lo, 64'd0);
    @(posedge clk); #1;
    valid_in = 1'b0;
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      ex_ctrl = tbl[i].ctrl; instruction = tbl[i].ins;
      reg1 = tbl[i].a; reg2 = tbl[i].b; sign_extend = tbl[i].se; valid_in = 1'b1;
      @(negedge clk);
      check("tbl_result", alu_result, tbl[i].exp_res);
      check("tbl_zero", zero, tbl[i].exp_zero);
      check("tbl_dest", dest_reg, tbl[i].exp_dest);
      check("tbl_stall", stall, 64'd0);
    end
    @(posedge clk); #1;
    valid_in = 1'b0;

    for (int i = 0; i < 6; i++) run_md(mdt[i].f, mdt[i].a, mdt[i].b);

    for (int i = 0; i < 16; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      a = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 100) : $urandom;
      b = ($urandom_range(0, 5) == 0) ? 32'd0 : (($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 9)) : $urandom);
      if ($urandom_range(0, 7) == 0) b = 32'hFFFF_FFFF;
      run_md(6'(6'h18 + $urandom_range(0, 3)), a, b);
    end

    for (int i = 0; i < 200; i++) begin
      logic [5:0] f;
      @(posedge clk); #1;
      f = fpool[$urandom_range(0, 19)];
      ex_ctrl = 4'($urandom_range(0, 15));
      instruction = ($urandom & 32'hFFFF_F800) | {21'd0, 5'($urandom_range(0, 31)), f};
      reg1 = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      reg2 = ($urandom_range(0, 3) == 0) ? reg1 : $urandom;
      sign_extend = 32'(int'(16'($urandom)));
      rt = 5'($urandom); rd = 5'($urandom);
      valid_in = 1'($urandom);
      if (ex_ctrl[2:1] == 2'b10 && f[5:2] == 4'b0110) valid_in = 1'b0;
      @(negedge clk);
      begin
        logic [31:0] e;
        e = ref_alu(ex_ctrl, instruction, reg1, reg2, sign_extend, m_hi, m_lo);
        check("rnd_result", alu_result, e);
        check("rnd_zero", zero, (e == 0) ? 64'd1 : 64'd0);
        check("rnd_dest", dest_reg, ex_ctrl[3] ? rd : rt);
        check("rnd_stall", stall, 64'd0);
      end
    end
    @(posedge clk); #1;
    valid_in = 1'b0; ex_ctrl = 4'b1100; rt = 5'd4; rd = 5'd9;

    // Flush with a start pending: no op begins.
    valid_in = 1'b1; instruction = mk_instr(5'd0, 6'h18); flush = 1'b1;
    @(negedge clk);
    check("flush_start_stall", stall, 64'd0);
    @(posedge clk); #1;
    flush = 1'b0; valid_in = 1'b0;
    @(negedge clk);
    check("flush_start_idle", stall, 64'd0);

    // Flush at iteration 10 of a divide.
    run_md(6'h18, 32'hFFFF_FFFD, 32'd7);
    @(posedge clk); #1;
    valid_in = 1'b1; instruction = mk_instr(5'd0, 6'h1A); reg1 = 32'd100; reg2 = 32'd7;
    repeat (11) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    check("flush_mid_stall", stall, 64'd0);
    @(posedge clk); #1;
    flush = 1'b0; valid_in = 1'b0;
    @(negedge clk);
    check("flush_after_stall", stall, 64'd0);
    repeat (40) @(negedge clk);
    check("flush_hi_kept", hi, m_hi);
    check("flush_lo_kept", lo, m_lo);

    // Reset at iteration 10 of a divide.
    @(posedge clk); #1;
    valid_in = 1'b1; instruction = mk_instr(5'd0, 6'h1A); reg1 = 32'd100; reg2 = 32'd7;
    repeat (11) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rst_mid_stall", stall, 64'd0);
    check("rst_mid_hi", hi, 64'd0);
    check("rst_mid_lo", lo, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0; valid_in = 1'b0;
    m_hi = '0; m_lo = '0;
    repeat (40) @(negedge clk);
    check("rst_idle_stall", stall, 64'd0);
    check("rst_hi_kept", hi, 64'd0);
    run_md(6'h1B, 32'd100, 32'd7);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
